// File: rtl/dcache_tag_assoc.sv
// dcache_tag_assoc
//   N-way (2 or 4) set-associative tag/state array for the NPC data cache.
//   Keeps valid, dirty and tag per way/set plus tree-PLRU bits per set.
//   Lookup is combinational: hit/miss, victim choice and write-back need
//   are all reported in the same cycle as the request. Refills install the
//   request tag into the victim way; store hits mark the line dirty. A
//   two-state FSM sweeps every set once to invalidate the whole array.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   flush         kills the current lookup and every update it would cause
//   req_valid     access present this cycle
//   req_we        0 = load, 1 = store
//   req_cache     address is cacheable
//   req_addr      {tag, index, offset}
//   hit           one-hot hit way
//   miss          cacheable, looked-up access with no hit
//   stallreq      miss, or cacheable access while the sweep is running
//   victim        way to replace for the current index
//   write_back    miss and victim line is valid and dirty
//   wb_tag        tag of the victim line
//   refresh       refill done; install request tag into victim
//   inv_all       pulse that starts the invalidate sweep
//   inv_busy      sweep in progress
module dcache_tag_assoc #(
   parameter int WAYS     = 2,
   parameter int INDEX_W  = 6,
   parameter int OFFSET_W = 3,
   parameter int ADDR_W   = 64,
   localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W,
   localparam int WAY_W   = (WAYS > 2) ? 2 : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic              req_cache,
   input  logic [ADDR_W-1:0] req_addr,
   output logic [WAYS-1:0]   hit,
   output logic              miss,
   output logic              stallreq,
   output logic [WAY_W-1:0]  victim,
   output logic              write_back,
   output logic [TAG_W-1:0]  wb_tag,
   input  logic              refresh,
   input  logic              inv_all,
   output logic              inv_busy
);

   localparam int SETS = 1 << INDEX_W;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   // Address fields
   logic [TAG_W-1:0]   req_tag_s;
   logic [INDEX_W-1:0] index_s;
   logic               unused_offset_s;

   // State storage
   logic [WAYS-1:0]    valid_r [SETS];
   logic [WAYS-1:0]    dirty_r [SETS];
   logic [TAG_W-1:0]   tag_r   [SETS][WAYS];
   logic [WAYS-2:0]    plru_r  [SETS];

   // Sweep FSM
   state_t             state_r;
   state_t             state_nxt_s;
   logic [INDEX_W-1:0] sweep_cnt_r;
   logic               busy_s;

   // Lookup / replacement
   logic               look_s;
   logic [WAYS-1:0]    hit_s;
   logic               any_hit_s;
   logic               miss_s;
   logic [WAY_W-1:0]   hit_way_s;
   logic               inv_found_s;
   logic [WAY_W-1:0]   inv_way_s;
   logic [WAY_W-1:0]   plru_pick_s;
   logic [WAY_W-1:0]   victim_s;
   logic [WAY_W-1:0]   touch_way_s;
   logic [WAYS-2:0]    plru_cur_s;
   logic [WAYS-2:0]    plru_touch_s;
   logic               do_refresh_s;
   logic               store_hit_s;
   logic               touch_s;

   assign req_tag_s       = req_addr[ADDR_W-1 -: TAG_W];
   assign index_s         = req_addr[OFFSET_W +: INDEX_W];
   assign unused_offset_s = ^req_addr[OFFSET_W-1:0];

   assign busy_s = (state_r == SWEEP);
   // Reset is folded in so outputs read as idle while rst is held.
   assign look_s = req_valid & req_cache & ~flush & ~busy_s & ~rst;

   // Per-way tag compare for the addressed set
   always_comb begin
      hit_s = '0;
      for (int w = 0; w < WAYS; w++) begin
         hit_s[w] = look_s & valid_r[index_s][w] & (tag_r[index_s][w] == req_tag_s);
      end
   end

   assign any_hit_s = |hit_s;
   assign miss_s    = look_s & ~any_hit_s;

   // Encode the one-hot hit vector into a way number
   always_comb begin
      hit_way_s = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (hit_s[w]) begin
            hit_way_s = WAY_W'(w);
         end else begin
            hit_way_s = hit_way_s;
         end
      end
   end

   // Find the lowest-numbered invalid way in the addressed set
   always_comb begin
      inv_found_s = 1'b0;
      inv_way_s   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!inv_found_s && !valid_r[index_s][w]) begin
            inv_found_s = 1'b1;
            inv_way_s   = WAY_W'(w);
         end else begin
            inv_found_s = inv_found_s;
         end
      end
   end

   assign plru_cur_s  = plru_r[index_s];
   assign victim_s    = inv_found_s ? inv_way_s : plru_pick_s;
   // A refill is only possible on a miss, so hit and refresh never touch together.
   assign touch_way_s = any_hit_s ? hit_way_s : victim_s;

   // Tree-PLRU: each bit points at the less recently used side.
   // 4-way: bit0 selects half (0 = ways 0/1), bit1 picks within 0/1, bit2 within 2/3.
   generate
      if (WAYS == 4) begin : g_plru4
         // Victim pick and MRU update for the 3-bit tree
         always_comb begin
            plru_pick_s     = plru_cur_s[0] ? {1'b1, plru_cur_s[2]} : {1'b0, plru_cur_s[1]};
            plru_touch_s    = plru_cur_s;
            plru_touch_s[0] = ~touch_way_s[1];
            if (touch_way_s[1]) begin
               plru_touch_s[2] = ~touch_way_s[0];
            end else begin
               plru_touch_s[1] = ~touch_way_s[0];
            end
         end
      end else begin : g_plru2
         // Single bit names the LRU way directly
         always_comb begin
            plru_pick_s  = plru_cur_s;
            plru_touch_s = ~touch_way_s;
         end
      end
   endgenerate

   assign do_refresh_s = refresh & miss_s;
   assign store_hit_s  = any_hit_s & req_we;
   assign touch_s      = any_hit_s | do_refresh_s;

   assign hit        = hit_s;
   assign miss       = miss_s;
   assign stallreq   = ~rst & (miss_s | (req_valid & req_cache & busy_s));
   assign victim     = victim_s;
   assign write_back = miss_s & valid_r[index_s][victim_s] & dirty_r[index_s][victim_s];
   assign wb_tag     = tag_r[index_s][victim_s];
   assign inv_busy   = busy_s;

   // Sweep FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Sweep FSM next state; inv_all is ignored once sweeping
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (inv_all) begin
               state_nxt_s = SWEEP;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SWEEP: begin
            if (sweep_cnt_r == {INDEX_W{1'b1}}) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = SWEEP;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Sweep counter: held at 0 while idle so each sweep starts at set 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sweep_cnt_r <= '0;
      end else if (busy_s) begin
         sweep_cnt_r <= sweep_cnt_r + {{(INDEX_W-1){1'b0}}, 1'b1};
      end else begin
         sweep_cnt_r <= '0;
      end
   end

   // Valid, dirty and PLRU state: reset, sweep clear, refill and hit updates
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            valid_r[s] <= '0;
            dirty_r[s] <= '0;
            plru_r[s]  <= '0;
         end
      end else if (busy_s) begin
         valid_r[sweep_cnt_r] <= '0;
         dirty_r[sweep_cnt_r] <= '0;
         plru_r[sweep_cnt_r]  <= '0;
      end else begin
         if (do_refresh_s) begin
            valid_r[index_s][victim_s] <= 1'b1;
            dirty_r[index_s][victim_s] <= req_we;
         end
         if (store_hit_s) begin
            dirty_r[index_s][hit_way_s] <= 1'b1;
         end
         if (touch_s) begin
            plru_r[index_s] <= plru_touch_s;
         end
      end
   end

   // Tag storage is not reset; valid bits qualify it
   always_ff @(posedge clk) begin
      if (do_refresh_s) begin
         tag_r[index_s][victim_s] <= req_tag_s;
      end
   end

endmodule

// File: tb/tb_dcache_tag_assoc.sv
// Directed self-checking bench for dcache_tag_assoc: a 2-way and a 4-way
// instance share clock and reset. Inputs change 1 time unit after the rising
// edge; combinational outputs are sampled before the next edge.
module tb_dcache_tag_assoc;

   logic        clk;
   logic        rst;

   // 2-way instance
   logic        flush, req_valid, req_we, req_cache, refresh, inv_all;
   logic [63:0] req_addr;
   logic [1:0]  hit;
   logic        miss, stallreq, write_back, inv_busy;
   logic [0:0]  victim;
   logic [54:0] wb_tag;

   // 4-way instance
   logic        q_flush, q_req_valid, q_req_we, q_req_cache, q_refresh, q_inv_all;
   logic [63:0] q_req_addr;
   logic [3:0]  q_hit;
   logic        q_miss, q_stallreq, q_write_back, q_inv_busy;
   logic [1:0]  q_victim;
   logic [54:0] q_wb_tag;

   int tests_run;
   int tests_failed;
   int busy_cycles;

   dcache_tag_assoc #(.WAYS(2)) dut (
      .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_we(req_we),
      .req_cache(req_cache), .req_addr(req_addr), .hit(hit), .miss(miss),
      .stallreq(stallreq), .victim(victim), .write_back(write_back), .wb_tag(wb_tag),
      .refresh(refresh), .inv_all(inv_all), .inv_busy(inv_busy)
   );

   dcache_tag_assoc #(.WAYS(4)) dut4 (
      .clk(clk), .rst(rst), .flush(q_flush), .req_valid(q_req_valid), .req_we(q_req_we),
      .req_cache(q_req_cache), .req_addr(q_req_addr), .hit(q_hit), .miss(q_miss),
      .stallreq(q_stallreq), .victim(q_victim), .write_back(q_write_back), .wb_tag(q_wb_tag),
      .refresh(q_refresh), .inv_all(q_inv_all), .inv_busy(q_inv_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [63:0] mk_addr(input logic [54:0] tag, input logic [5:0] idx);
      return {tag, idx, 3'b000};
   endfunction

   task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req2(input logic v, input logic we, input logic [63:0] a);
      req_valid = v;
      req_we    = we;
      req_cache = 1'b1;
      req_addr  = a;
      #1;
   endtask

   task automatic req4(input logic v, input logic we, input logic [63:0] a);
      q_req_valid = v;
      q_req_we    = we;
      q_req_cache = 1'b1;
      q_req_addr  = a;
      #1;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst = 1'b0;
      flush = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_cache = 1'b0;
      refresh = 1'b0; inv_all = 1'b0; req_addr = 64'd0;
      q_flush = 1'b0; q_req_valid = 1'b0; q_req_we = 1'b0; q_req_cache = 1'b0;
      q_refresh = 1'b0; q_inv_all = 1'b0; q_req_addr = 64'd0;
      #1 rst = 1'b1;

      // Outputs held quiet during reset even with a live request
      req2(1'b1, 1'b0, 64'h0000_0000_8000_0040);
      check_eq("rst_hit", 64'(hit), 64'd0);
      check_eq("rst_miss", 64'(miss), 64'd0);
      check_eq("rst_stall", 64'(stallreq), 64'd0);
      check_eq("rst_busy", 64'(inv_busy), 64'd0);
      tick();
      tick();
      rst = 1'b0;
      #1;

      // First load after reset misses into way 0, refill, then hits
      check_eq("cold_miss", 64'(miss), 64'd1);
      check_eq("cold_hit", 64'(hit), 64'd0);
      check_eq("cold_victim", 64'(victim), 64'd0);
      check_eq("cold_wb", 64'(write_back), 64'd0);
      check_eq("cold_stall", 64'(stallreq), 64'd1);
      refresh = 1'b1;
      tick();
      refresh = 1'b0;
      #1;
      check_eq("refill_hit", 64'(hit), 64'd1);
      check_eq("refill_miss", 64'(miss), 64'd0);
      check_eq("refill_stall", 64'(stallreq), 64'd0);

      // Set 1: A -> way0, B -> way1, store A, load B, then C evicts dirty A
      req2(1'b1, 1'b0, mk_addr(55'h11, 6'd1));
      check_eq("fillA_victim", 64'(victim), 64'd0);
      refresh = 1'b1; tick(); refresh = 1'b0;
      req2(1'b1, 1'b0, mk_addr(55'h22, 6'd1));
      check_eq("fillB_miss", 64'(miss), 64'd1);
      check_eq("fillB_victim", 64'(victim), 64'd1);
      refresh = 1'b1; tick(); refresh = 1'b0;
      req2(1'b1, 1'b1, mk_addr(55'h11, 6'd1));
      check_eq("storeA_hit", 64'(hit), 64'd1);
      tick();
      req2(1'b1, 1'b0, mk_addr(55'h22, 6'd1));
      check_eq("loadB_hit", 64'(hit), 64'd2);
      tick();
      req2(1'b1, 1'b0, mk_addr(55'h33, 6'd1));
      check_eq("loadC_miss", 64'(miss), 64'd1);
      check_eq("loadC_victim", 64'(victim), 64'd0);
      check_eq("loadC_wb", 64'(write_back), 64'd1);
      check_eq("loadC_wbtag", 64'(wb_tag), 64'h11);

      // Uncached access: no lookup
      req_cache = 1'b0;
      req_addr  = mk_addr(55'h11, 6'd1);
      #1;
      check_eq("uc_hit", 64'(hit), 64'd0);
      check_eq("uc_miss", 64'(miss), 64'd0);
      check_eq("uc_stall", 64'(stallreq), 64'd0);

      // Flush suppresses lookup and drops a concurrent refresh
      flush = 1'b1;
      req2(1'b1, 1'b0, mk_addr(55'h11, 6'd1));
      check_eq("flush_hit", 64'(hit), 64'd0);
      check_eq("flush_miss", 64'(miss), 64'd0);
      check_eq("flush_stall", 64'(stallreq), 64'd0);
      req2(1'b1, 1'b0, mk_addr(55'h33, 6'd1));
      refresh = 1'b1;
      tick();
      refresh = 1'b0;
      flush = 1'b0;
      #1;
      check_eq("flush_drop_miss", 64'(miss), 64'd1);
      check_eq("flush_drop_hit", 64'(hit), 64'd0);

      // Invalidate sweep: A hits before, busy exactly 64 cycles, then misses clean
      req2(1'b1, 1'b0, mk_addr(55'h11, 6'd1));
      check_eq("pre_inv_hit", 64'(hit), 64'd1);
      req_valid = 1'b0;
      inv_all = 1'b1;
      tick();
      inv_all = 1'b0;
      check_eq("inv_busy_start", 64'(inv_busy), 64'd1);
      req2(1'b1, 1'b0, mk_addr(55'h11, 6'd1));
      check_eq("inv_req_stall", 64'(stallreq), 64'd1);
      check_eq("inv_req_miss", 64'(miss), 64'd0);
      check_eq("inv_req_hit", 64'(hit), 64'd0);
      req_valid = 1'b0;
      busy_cycles = 0;
      while (inv_busy && busy_cycles < 200) begin
         busy_cycles++;
         inv_all = (busy_cycles == 10);
         tick();
      end
      inv_all = 1'b0;
      check_eq("inv_busy_len", 64'(busy_cycles), 64'd64);
      tick();
      check_eq("inv_busy_after", 64'(inv_busy), 64'd0);
      req2(1'b1, 1'b0, mk_addr(55'h11, 6'd1));
      check_eq("post_inv_miss", 64'(miss), 64'd1);
      check_eq("post_inv_wb", 64'(write_back), 64'd0);
      check_eq("post_inv_victim", 64'(victim), 64'd0);
      req_valid = 1'b0;

      // 4-way PLRU: fill ways 0-3 in set 5, touch A then C
      for (int i = 0; i < 4; i++) begin
         req4(1'b1, 1'b0, mk_addr(55'hA1 + 55'(i), 6'd5));
         check_eq("q_fill_miss", 64'(q_miss), 64'd1);
         check_eq("q_fill_victim", 64'(q_victim), 64'(i));
         q_refresh = 1'b1; tick(); q_refresh = 1'b0;
      end
      req4(1'b1, 1'b0, mk_addr(55'hA1, 6'd5));
      check_eq("q_hitA", 64'(q_hit), 64'h1);
      tick();
      req4(1'b1, 1'b0, mk_addr(55'hA3, 6'd5));
      check_eq("q_hitC", 64'(q_hit), 64'h4);
      tick();
      req4(1'b1, 1'b0, mk_addr(55'hA5, 6'd5));
      check_eq("q_missE", 64'(q_miss), 64'd1);
      check_eq("q_victimE", 64'(q_victim), 64'd1);
      check_eq("q_wbtagE", 64'(q_wb_tag), 64'hA2);
      q_refresh = 1'b1; tick(); q_refresh = 1'b0;
      #1;
      check_eq("q_hitE", 64'(q_hit), 64'h2);
      req4(1'b1, 1'b0, mk_addr(55'hA6, 6'd5));
      check_eq("q_victimF", 64'(q_victim), 64'd3);
      check_eq("q_wbF", 64'(q_write_back), 64'd0);
      q_req_valid = 1'b0;

      // Async reset at sweep counter 20 clears busy and not-yet-swept sets
      req2(1'b1, 1'b0, mk_addr(55'h55, 6'd40));
      refresh = 1'b1; tick(); refresh = 1'b0;
      #1;
      check_eq("s40_hit", 64'(hit), 64'd1);
      req_valid = 1'b0;
      inv_all = 1'b1;
      tick();
      inv_all = 1'b0;
      repeat (20) tick();
      check_eq("mid_sweep_busy", 64'(inv_busy), 64'd1);
      #2 rst = 1'b1;
      #1;
      check_eq("async_rst_busy", 64'(inv_busy), 64'd0);
      #1 rst = 1'b0;
      req2(1'b1, 1'b0, mk_addr(55'h55, 6'd40));
      check_eq("post_rst_miss40", 64'(miss), 64'd1);
      check_eq("post_rst_hit40", 64'(hit), 64'd0);
      req4(1'b1, 1'b0, mk_addr(55'hA1, 6'd5));
      check_eq("q_post_rst_miss", 64'(q_miss), 64'd1);
      tick();
      check_eq("post_rst_busy", 64'(inv_busy), 64'd0);
      req_valid = 1'b0;
      q_req_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
